dds_wavetable_gen: RTL

Parametrised multi-channel direct-digital-synthesis front end for the sine-table RAM. It keeps one phase accumulator and one tuning word per channel and time-multiplexes reads of a single external synchronous table port round-robin. It re-attaches channel tags to the returned data after the RAM read latency and emits tagged samples. Optional quarter-wave mode stores only the first quadrant and reconstructs the full period by symmetry.

---
 rtl/dds_pkg.sv | 24 ++
 rtl/dds_tag_pipe.sv | 33 +++
 rtl/dds_wavetable_gen.sv | 129 ++++++++++++
 3 files changed

// File: rtl/dds_pkg.sv
// Shared types and helpers for the DDS wavetable front end.
// Quadrant encoding and width/scale functions used by the top and the bench.
package dds_pkg;

    typedef enum logic [1:0] {
        Q_RISE     = 2'd0,
        Q_FALL     = 2'd1,
        Q_NEG_RISE = 2'd2,
        Q_NEG_FALL = 2'd3
    } quadrant_e;

    function automatic int unsigned ch_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned midscale(input int unsigned w);
        return 1 << (w - 1);
    endfunction

    function automatic int unsigned full_scale(input int unsigned w);
        return (1 << w) - 1;
    endfunction

endpackage

// File: rtl/dds_tag_pipe.sv
// Delay line carrying {valid, channel, invert} alongside the table read latency.
module dds_tag_pipe #(
    parameter int unsigned ROM_LAT = 2,
    parameter int unsigned CH_W    = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            issue_valid,
    input  logic [CH_W-1:0] issue_ch,
    input  logic            issue_invert,
    output logic            tag_valid,
    output logic [CH_W-1:0] tag_ch,
    output logic            tag_invert
);

    logic [CH_W+1:0] stage [ROM_LAT];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < ROM_LAT; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= {issue_valid, issue_ch, issue_invert};
            for (int unsigned i = 1; i < ROM_LAT; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign {tag_valid, tag_ch, tag_invert} = stage[ROM_LAT-1];

endmodule

// File: rtl/dds_wavetable_gen.sv
// Multi-channel DDS front end: round-robin phase accumulators sharing one
// synchronous sine-table port, with optional quarter-wave reconstruction.
module dds_wavetable_gen
    import dds_pkg::*;
#(
    parameter int unsigned NUM_CH       = 2,
    parameter int unsigned PHASE_W      = 16,
    parameter int unsigned ADDR_W       = 10,
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned ROM_LAT      = 2,
    parameter int unsigned QUARTER_WAVE = 0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           en,
    input  logic                           phase_clr,
    input  logic                           freq_wr,
    input  logic [ch_width(NUM_CH)-1:0]    freq_ch,
    input  logic [PHASE_W-1:0]             freq_word,
    output logic                           rom_en,
    output logic [ADDR_W-1:0]              rom_addr,
    input  logic [DATA_W-1:0]              rom_data,
    output logic                           sample_valid,
    output logic [ch_width(NUM_CH)-1:0]    sample_ch,
    output logic [DATA_W-1:0]              sample
);

    localparam int unsigned       CH_W = ch_width(NUM_CH);
    localparam logic [DATA_W-1:0] FULL = DATA_W'(full_scale(DATA_W));

    logic [PHASE_W-1:0] phase [NUM_CH];
    logic [PHASE_W-1:0] tw    [NUM_CH];
    logic [CH_W-1:0]    cur_ch;
    logic [CH_W-1:0]    rom_ch;
    logic               rom_inv;
    logic [PHASE_W-1:0] cur_phase;
    logic [ADDR_W-1:0]  next_addr;
    logic               next_inv;
    logic               freq_ok;
    logic               tag_valid;
    logic [CH_W-1:0]    tag_ch;
    logic               tag_inv;

    assign cur_phase = phase[cur_ch];

    generate
        if (QUARTER_WAVE != 0) begin : g_quarter
            quadrant_e         quad;
            logic [ADDR_W-1:0] a;
            always_comb begin
                quad      = quadrant_e'(cur_phase[PHASE_W-1 -: 2]);
                a         = cur_phase[PHASE_W-3 -: ADDR_W];
                next_addr = (quad == Q_FALL || quad == Q_NEG_FALL) ? ~a : a;
                next_inv  = (quad == Q_NEG_RISE || quad == Q_NEG_FALL);
            end
        end else begin : g_full
            assign next_addr = cur_phase[PHASE_W-1 -: ADDR_W];
            assign next_inv  = 1'b0;
        end

        // Out-of-range channel writes can only occur when NUM_CH is not a power of two.
        if (NUM_CH == (1 << CH_W)) begin : g_ch_pow2
            assign freq_ok = 1'b1;
        end else begin : g_ch_range
            assign freq_ok = (freq_ch < CH_W'(NUM_CH));
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                phase[i] <= '0;
                tw[i]    <= '0;
            end
            cur_ch   <= '0;
            rom_en   <= 1'b0;
            rom_addr <= '0;
            rom_ch   <= '0;
            rom_inv  <= 1'b0;
        end else begin
            rom_en <= en && !phase_clr;
            if (phase_clr) begin
                for (int unsigned i = 0; i < NUM_CH; i++) begin
                    phase[i] <= '0;
                end
                cur_ch <= '0;
            end else if (en) begin
                rom_addr      <= next_addr;
                rom_ch        <= cur_ch;
                rom_inv       <= next_inv;
                phase[cur_ch] <= cur_phase + tw[cur_ch];
                cur_ch        <= (cur_ch == CH_W'(NUM_CH - 1)) ? '0 : cur_ch + 1'b1;
            end
            // Same-cycle write to the issuing channel lands after this accumulation.
            if (freq_wr && freq_ok) begin
                tw[freq_ch] <= freq_word;
            end
        end
    end

    dds_tag_pipe #(
        .ROM_LAT (ROM_LAT),
        .CH_W    (CH_W)
    ) u_tag_pipe (
        .clk          (clk),
        .rst          (rst),
        .issue_valid  (rom_en),
        .issue_ch     (rom_ch),
        .issue_invert (rom_inv),
        .tag_valid    (tag_valid),
        .tag_ch       (tag_ch),
        .tag_invert   (tag_inv)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_valid <= 1'b0;
            sample_ch    <= '0;
            sample       <= '0;
        end else begin
            sample_valid <= tag_valid;
            if (tag_valid) begin
                sample_ch <= tag_ch;
                sample    <= tag_inv ? (FULL - rom_data) : rom_data;
            end
        end
    end

endmodule
